// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the fetch stage.
// Word type, fetch FSM states and the F/D bundle.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      RUN,
      REDIRECT_PEND,
      HALTED
   } fetch_state_t;

   typedef struct packed {
      word_t instr;
      word_t npc;
      logic  valid;
   } fd_latch_t;

   localparam word_t NOP_INSTR = 32'h0;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-cache request/response bus.
// master = fetch stage, slave = icache.
interface fetch_unit_if;
   import cpu_types_pkg::*;

   logic  ihit;
   word_t imemload;
   logic  imemREN;
   word_t imemaddr;

   modport master (
      input  ihit,
      input  imemload,
      output imemREN,
      output imemaddr
   );

   modport slave (
      output ihit,
      output imemload,
      input  imemREN,
      input  imemaddr
   );

endinterface

// File: rtl/fd_latch.sv
// Pipeline stage latch with enable, bubble insert and hold.
// Bubble wins over enable; neither asserted holds contents.
module fd_latch
   import cpu_types_pkg::*;
(
   input  logic      CLK,
   input  logic      nRST,
   input  logic      en,
   input  logic      bubble,
   input  fd_latch_t d,
   output fd_latch_t q
);

   // latch update: reset, bubble, load or hold
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         q <= '{instr: NOP_INSTR, npc: '0, valid: 1'b0};
      end else if (bubble) begin
         q <= '{instr: NOP_INSTR, npc: '0, valid: 1'b0};
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, icache request, F/D latch fill.
// Handles redirects during outstanding misses and halt freeze.
module fetch_unit
   import cpu_types_pkg::*;
#(
   parameter word_t PC0 = 32'h00000000
)
(
   input  logic    CLK,
   input  logic    nRST,
   fetch_unit_if.master imem,
   input  logic    pcEN,
   input  logic    fdEN,
   input  logic    redirect,
   input  word_t   redirect_pc,
   input  logic    halt,
   output word_t   fd_instr,
   output word_t   fd_npc,
   output logic    fd_valid
);

   fetch_state_t state;
   word_t        pc;
   word_t        pend_pc;
   word_t        npc;
   word_t        tgt;
   logic         acc;
   logic         fd_en;
   logic         fd_bub;
   fd_latch_t    fd_d;
   fd_latch_t    fd_q;

   assign npc = pc + 32'd4;
   assign tgt = redirect_pc & ~32'h3;
   assign acc = imem.ihit & pcEN;

   assign imem.imemaddr = pc;
   assign imem.imemREN  = (state != HALTED);

   // PC and redirect/halt sequencing
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state   <= RUN;
         pc      <= PC0;
         pend_pc <= '0;
      end else begin
         unique case (state)
            RUN: begin
               if (halt) begin
                  state <= HALTED;
               end else if (redirect & imem.ihit) begin
                  pc <= tgt;
               end else if (redirect) begin
                  pend_pc <= tgt;
                  state   <= REDIRECT_PEND;
               end else if (acc) begin
                  pc <= npc;
               end
            end
            REDIRECT_PEND: begin
               if (halt) begin
                  state <= HALTED;
               end else if (imem.ihit) begin
                  pc    <= redirect ? tgt : pend_pc;
                  state <= RUN;
               end else if (redirect) begin
                  pend_pc <= tgt;
               end
            end
            HALTED: begin
               state <= HALTED;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

   // F/D latch control: load on accepted fetch, bubble otherwise
   always_comb begin
      fd_en  = 1'b0;
      fd_bub = 1'b0;
      fd_d   = '{instr: imem.imemload, npc: npc, valid: 1'b1};
      unique case (1'b1)
         (state == RUN): begin
            if (halt | redirect) begin
               fd_bub = 1'b1;
            end else if (fdEN) begin
               fd_en  = acc;
               fd_bub = ~acc;
            end
         end
         (state == REDIRECT_PEND): begin
            fd_bub = 1'b1;
         end
         default: begin
            fd_en  = 1'b0;
            fd_bub = 1'b0;
         end
      endcase
   end

   fd_latch u_fd (
      .CLK    (CLK),
      .nRST   (nRST),
      .en     (fd_en),
      .bubble (fd_bub),
      .d      (fd_d),
      .q      (fd_q)
   );

   assign fd_instr = fd_q.instr;
   assign fd_npc   = fd_q.npc;
   assign fd_valid = fd_q.valid;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; the block that acts on the hazard unit's pcEN/fdEN stall decisions.
- Owns the PC register, drives the icache request, and fills the fetch/decode (F/D) pipeline latch.
- Handles branch/jump redirects, including one that arrives while an icache miss is outstanding.
- Freezes permanently on halt.

Parameters:
- PC0, 32'h00000000, PC value loaded on reset.

Ports:
- CLK  in  1  pipeline clock
- nRST  in  1  reset; synchronous, active-low
- ihit  in  1  icache returns valid imemload this cycle
- imemload  in  32  instruction word from icache
- imemREN  out  1  icache read enable
- imemaddr  out  32  icache address (word_t)
- pcEN  in  1  PC advance enable, from hazard unit
- fdEN  in  1  F/D latch enable, from hazard unit
- redirect  in  1  taken branch/jump resolved downstream
- redirect_pc  in  32  redirect target
- halt  in  1  halt instruction committed
- fd_instr  out  32  F/D instruction
- fd_npc  out  32  F/D PC+4
- fd_valid  out  1  F/D holds a real instruction

Behaviour:
- All state updates on posedge CLK. Reset is synchronous: nRST=0 at an edge gives pc=PC0, state=RUN, fd_instr=0, fd_npc=0, fd_valid=0, pend_pc=0. Reset overrides everything, including REDIRECT_PEND and HALTED mid-operation.
- Outputs: imemaddr=pc (combinational); imemREN=1 in RUN and REDIRECT_PEND, 0 in HALTED.
- Arithmetic: npc = pc+4, modulo 2^32 (32'hFFFFFFFC+4 = 0). redirect_pc[1:0] are forced to 2'b00 when captured.
- Define acc = ihit & pcEN (fetch accepted).
- States: RUN, REDIRECT_PEND, HALTED.
- RUN:
  - halt=1 -> HALTED. pc holds; F/D loads a bubble (instr 0, valid 0). halt has priority over redirect.
  - else redirect=1 & (ihit | ~imemREN-in-flight): pc<=redirect_pc, F/D bubble, stay RUN. Treat any redirect with ihit=1 as an immediate redirect.
  - else redirect=1 & ihit=0: pend_pc<=redirect_pc, -> REDIRECT_PEND. pc and imemaddr stay stable so the in-flight miss completes. F/D bubble.
  - else acc: pc<=npc.
  - else: pc holds.
- F/D update in RUN with no redirect/halt:
  - fdEN & acc: fd_instr<=imemload, fd_npc<=npc, fd_valid<=1.
  - fdEN & ~acc: bubble (0, 0, 0).
  - ~fdEN: hold all F/D values.
- REDIRECT_PEND:
  - F/D holds bubble; fd_valid=0.
  - ihit=1: discard imemload, pc<=pend_pc, -> RUN.
  - New redirect while pending: pend_pc<=new target (latest wins).
  - halt -> HALTED.
- HALTED: pc, F/D hold; fd_valid=0; imemREN=0. Exits only by reset.
- Latency: instruction presented with ihit at edge N appears on fd_* after edge N. Redirect without miss: target is on imemaddr the cycle after the redirect edge.

Decomposition:
- cpu_types_pkg additions:
  - fetch_state_t enum {RUN, REDIRECT_PEND, HALTED}
  - fd_latch_t struct {word_t instr; word_t npc; logic valid;}
  - constant NOP_INSTR = 32'h0
- Sub-module fd_latch: F/D register with enable/bubble/hold and synchronous active-low reset. It is reused as the template for the later stage latches.

Test Plan:
- Reset: nRST=0 for 2 cycles, PC0=32'h100 -> imemaddr=32'h100, imemREN=1, fd_valid=0. Then ihit=1, pcEN=fdEN=1, imemload=32'h2001000A -> fd_instr=32'h2001000A, fd_npc=32'h104, imemaddr=32'h104.
- Stall: pcEN=fdEN=0 for 3 cycles with ihit=1 -> pc and F/D unchanged. pcEN=0, fdEN=1 -> F/D becomes bubble, pc held.
- Redirect on hit: pc=32'h20, redirect=1, redirect_pc=32'h83, ihit=1 -> next imemaddr=32'h80, fd_valid=0.
- Redirect during miss: ihit=0, redirect to 32'h200, a second redirect to 32'h300 while pending, ihit=1 after 4 cycles -> imemaddr stays at the old pc until ihit, then 32'h300. Returned word is never latched.
- Halt: halt=1 together with redirect=1 -> HALTED, imemREN=0, pc unchanged for 10 cycles. nRST=0 -> pc=PC0, RUN.
- Wrap: pc=32'hFFFFFFFC, accepted fetch -> pc=0, fd_npc=0.
